// File: rtl/wrr_arbiter_if.sv
// -----------------------------------------------------------------------------
// wrr_arbiter_if
//   Bundles the requester-side and grant-side signals of the weighted
//   round-robin arbiter.
//   Parameters:
//     NUM_PORTS  number of requesters
//     WEIGHT_W   width of the per-port weight / credit counter
//   Signals:
//     request     [NUM_PORTS]           per-port request level
//     last        [NUM_PORTS]           per-port end-of-transaction flag (qualified by ack)
//     weight      [NUM_PORTS*WEIGHT_W]  per-port credits per tenure
//     ack                               downstream accepted a beat from the granted port
//     grant       [NUM_PORTS]           one-hot grant
//     select      [SEL_WIDTH]           index of the granted port
//     active                            a grant is held
//     credit_left [WEIGHT_W]            transactions remaining in the current tenure
//   Modports:
//     master  requester / downstream side (drives requests, sees grants)
//     slave   arbiter side (sees requests, drives grants)
// -----------------------------------------------------------------------------
interface wrr_arbiter_if #(
    parameter int NUM_PORTS = 8,
    parameter int WEIGHT_W  = 4
);
    localparam int SEL_WIDTH = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [NUM_PORTS-1:0]          request;
    logic [NUM_PORTS-1:0]          last;
    logic [NUM_PORTS*WEIGHT_W-1:0] weight;
    logic                          ack;
    logic [NUM_PORTS-1:0]          grant;
    logic [SEL_WIDTH-1:0]          select;
    logic                          active;
    logic [WEIGHT_W-1:0]           credit_left;

    modport master (
        output request, last, weight, ack,
        input  grant, select, active, credit_left
    );

    modport slave (
        input  request, last, weight, ack,
        output grant, select, active, credit_left
    );
endinterface

// File: rtl/wrr_arbiter.sv
// -----------------------------------------------------------------------------
// wrr_arbiter
//   Weighted round-robin arbiter with transaction-level grant hold. A winner
//   is chosen circularly starting at the rotation pointer, keeps the grant for
//   'weight' completed transactions (0 counts as 1), then releases with a
//   one-cycle bubble and the pointer moves past it.
//   Ports:
//     clk    in  rising-edge clock
//     rstn   in  asynchronous active-low reset
//     bus    wrr_arbiter_if.slave: request/last/weight/ack in,
//            grant/select/active/credit_left out (all outputs registered)
// -----------------------------------------------------------------------------
module wrr_arbiter #(
    parameter int NUM_PORTS = 8,
    parameter int WEIGHT_W  = 4
) (
    input  logic           clk,
    input  logic           rstn,
    wrr_arbiter_if.slave   bus
);
    localparam int SEL_WIDTH = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [WEIGHT_W-1:0]  CREDIT_ONE = WEIGHT_W'(1);
    localparam logic [NUM_PORTS-1:0] ONEHOT_0   = NUM_PORTS'(1);
    localparam logic [SEL_WIDTH-1:0] SEL_LAST   = SEL_WIDTH'(NUM_PORTS - 1);
    localparam logic [SEL_WIDTH-1:0] SEL_ONE    = SEL_WIDTH'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t                 r_state;
    logic [NUM_PORTS-1:0]   r_grant;
    logic [SEL_WIDTH-1:0]   r_select;
    logic                   r_active;
    logic [WEIGHT_W-1:0]    r_credit;
    logic [SEL_WIDTH-1:0]   r_ptr;

    state_t                 w_state_nxt;
    logic [NUM_PORTS-1:0]   w_grant_nxt;
    logic [SEL_WIDTH-1:0]   w_select_nxt;
    logic                   w_active_nxt;
    logic [WEIGHT_W-1:0]    w_credit_nxt;
    logic [SEL_WIDTH-1:0]   w_ptr_nxt;

    logic                   w_found;
    logic [SEL_WIDTH-1:0]   w_winner;
    logic [SEL_WIDTH-1:0]   w_cand;
    int                     w_idx;
    logic                   w_release;
    logic [WEIGHT_W-1:0]    w_weight [NUM_PORTS];
    logic [WEIGHT_W-1:0]    w_win_weight;

    // Unpack the flat weight bus into a per-port array.
    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_weight
        assign w_weight[g] = bus.weight[g*WEIGHT_W +: WEIGHT_W];
    end

    // Circular priority search: first requester at or after r_ptr.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        w_idx    = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_idx = int'(r_ptr) + i;
            if (w_idx >= NUM_PORTS) begin
                w_idx = w_idx - NUM_PORTS;
            end else begin
                w_idx = w_idx;
            end
            w_cand = SEL_WIDTH'(w_idx);
            if (!w_found && bus.request[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end else begin
                w_found  = w_found;
            end
        end
    end

    // Weight of the winner; a zero weight still grants one transaction.
    always_comb begin
        if (w_weight[w_winner] == '0) begin
            w_win_weight = CREDIT_ONE;
        end else begin
            w_win_weight = w_weight[w_winner];
        end
    end

    // Next-state and next-output logic for the IDLE/HOLD machine.
    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_select_nxt = r_select;
        w_active_nxt = r_active;
        w_credit_nxt = r_credit;
        w_ptr_nxt    = r_ptr;
        w_release    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt  = ST_HOLD;
                    w_grant_nxt  = ONEHOT_0 << w_winner;
                    w_select_nxt = w_winner;
                    w_active_nxt = 1'b1;
                    w_credit_nxt = w_win_weight;
                end else begin
                    w_state_nxt  = ST_IDLE;
                end
            end
            ST_HOLD: begin
                // A completed transaction takes precedence over an abort when
                // the request drops in the same cycle.
                if (bus.ack && bus.last[r_select]) begin
                    if (r_credit > CREDIT_ONE) begin
                        w_credit_nxt = r_credit - CREDIT_ONE;
                    end else begin
                        w_release = 1'b1;
                    end
                end else if (!bus.ack && !bus.request[r_select]) begin
                    w_release = 1'b1;
                end else begin
                    w_release = 1'b0;
                end
                if (w_release) begin
                    w_state_nxt  = ST_IDLE;
                    w_grant_nxt  = '0;
                    w_active_nxt = 1'b0;
                    w_credit_nxt = '0;
                    w_ptr_nxt    = (r_select == SEL_LAST) ? '0 : (r_select + SEL_ONE);
                end else begin
                    w_state_nxt  = ST_HOLD;
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_grant_nxt  = '0;
                w_active_nxt = 1'b0;
                w_credit_nxt = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_select <= '0;
            r_active <= 1'b0;
            r_credit <= '0;
            r_ptr    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_select <= w_select_nxt;
            r_active <= w_active_nxt;
            r_credit <= w_credit_nxt;
            r_ptr    <= w_ptr_nxt;
        end
    end

    assign bus.grant       = r_grant;
    assign bus.select      = r_select;
    assign bus.active      = r_active;
    assign bus.credit_left = r_credit;
endmodule
